// File: rtl/booth_r4_seq_multiplier.sv
// rtl/booth_r4_seq_multiplier.sv - radix-4 Booth sequential multiplier, signed/unsigned operands
// Optional early termination when `BOOTH_EARLY_TERM_EN is defined (adds cycles_used output).
module booth_r4_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         is_signed,
    input  logic [WIDTH-1:0]             multiplicand,
    input  logic [WIDTH-1:0]             multiplier,
    output logic                         busy,
    output logic                         done,
`ifdef BOOTH_EARLY_TERM_EN
    output logic [$clog2(WIDTH/2+2)-1:0] cycles_used,
`endif
    output logic [2*WIDTH-1:0]           product
);
    localparam int N_ITER = WIDTH/2 + 1;
    localparam int CNT_W  = $clog2(WIDTH/2 + 2);
    localparam int EW     = WIDTH + 2;
    localparam int HW     = WIDTH + 3;
    localparam int PW     = HW + EW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [EW-1:0]        mcand;
    logic [EW-1:0]        acc_lo;
    logic [HW-1:0]        acc_hi;
    logic                 b_prev;
    logic [CNT_W-1:0]     iter;

    logic [HW-1:0]        addend;
    logic [HW-1:0]        sum;
    logic                 neg;
    logic signed [PW-1:0] pair;
    logic signed [PW-1:0] step_val;
    logic signed [PW-1:0] acc_next;
    logic                 last_iter;
    logic                 early;

    assign last_iter = (iter == CNT_W'(N_ITER - 1));

    // Booth digit from {B[i+1], B[i], B[i-1]}; negation is invert plus carry-in.
    always_comb begin
        addend = '0;
        neg    = 1'b0;
        case ({acc_lo[1:0], b_prev})
            3'b001, 3'b010: addend = {mcand[EW-1], mcand};
            3'b011:         addend = {mcand, 1'b0};
            3'b100: begin
                addend = {mcand, 1'b0};
                neg    = 1'b1;
            end
            3'b101, 3'b110: begin
                addend = {mcand[EW-1], mcand};
                neg    = 1'b1;
            end
            default: ;
        endcase
        sum      = acc_hi + (addend ^ {HW{neg}}) + {{(HW-1){1'b0}}, neg};
        pair     = {sum, acc_lo};
        step_val = pair >>> 2;
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic [EW-1:0] rem_mask;
    logic          rem_zero;
    logic          rem_ones;

    // After this digit, the unretired multiplier bits sit in the low bits of acc_lo.
    always_comb begin
        rem_mask = {EW{1'b1}} >> (2*int'(iter) + 2);
        rem_zero = ((step_val[EW-1:0] & rem_mask) == '0) && !acc_lo[1];
        rem_ones = ((step_val[EW-1:0] | ~rem_mask) == {EW{1'b1}}) && acc_lo[1];
        early    = !last_iter && (rem_zero || rem_ones);
        acc_next = early ? (step_val >>> (2*(N_ITER - 1 - int'(iter)))) : step_val;
    end
`else
    always_comb begin
        early    = 1'b0;
        acc_next = step_val;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter || early) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Product is loaded on the edge into DONE so it is valid alongside the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            b_prev  <= 1'b0;
            iter    <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
                        acc_lo <= {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
                        acc_hi <= '0;
                        b_prev <= 1'b0;
                        iter   <= '0;
                    end
                end
                S_CALC: begin
                    acc_hi <= acc_next[PW-1:EW];
                    acc_lo <= acc_next[EW-1:0];
                    b_prev <= acc_lo[1];
                    iter   <= iter + 1'b1;
                    if (last_iter || early) begin
                        product <= acc_next[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOOTH_EARLY_TERM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_used <= '0;
        end else if (state == S_CALC && (last_iter || early)) begin
            cycles_used <= iter + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_booth_r4_seq_multiplier.sv
// tb/tb_booth_r4_seq_multiplier.sv - directed-vector bench for booth_r4_seq_multiplier (WIDTH 32 and 8)
module tb_booth_r4_seq_multiplier;
    logic        clk = 1'b0;
    logic        rst;
    logic        s32, sg32, busy32, done32;
    logic [31:0] a32, b32;
    logic [63:0] p32;
    logic        s8, sg8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
`ifdef BOOTH_EARLY_TERM_EN
    logic [4:0]  cu32;
    logic [2:0]  cu8;
    logic [4:0]  last_cu32;
`endif
    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int pulses;

    always #5 clk = ~clk;

    booth_r4_seq_multiplier #(.WIDTH(32)) u_dut32 (
        .clk          (clk),
        .rst          (rst),
        .start        (s32),
        .is_signed    (sg32),
        .multiplicand (a32),
        .multiplier   (b32),
        .busy         (busy32),
        .done         (done32),
`ifdef BOOTH_EARLY_TERM_EN
        .cycles_used  (cu32),
`endif
        .product      (p32)
    );

    booth_r4_seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (s8),
        .is_signed    (sg8),
        .multiplicand (a8),
        .multiplier   (b8),
        .busy         (busy8),
        .done         (done8),
`ifdef BOOTH_EARLY_TERM_EN
        .cycles_used  (cu8),
`endif
        .product      (p8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic op32(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
        int l;
        @(negedge clk);
        s32 = 1'b1; sg32 = sgn; a32 = a; b32 = b;
        @(negedge clk);
        s32 = 1'b0; sg32 = ~sgn; a32 = ~a; b32 = ~b;
        check_eq({tag, " busy"}, 64'(busy32), 64'd1);
        l = 0;
        while (done32 !== 1'b1 && l < 40) begin
            @(negedge clk);
            l++;
        end
        check_eq({tag, " done seen"}, 64'(done32), 64'd1);
        check_eq({tag, " product"}, p32, exp);
`ifndef BOOTH_EARLY_TERM_EN
        check_eq({tag, " latency"}, 64'(l), 64'd17);
`else
        last_cu32 = cu32;
`endif
        @(negedge clk);
        check_eq({tag, " done/busy after"}, {62'd0, done32, busy32}, 64'd0);
    endtask

    task automatic op8(input string tag, input logic sgn, input logic [7:0] a,
                       input logic [7:0] b, input logic [15:0] exp);
        int l;
        @(negedge clk);
        s8 = 1'b1; sg8 = sgn; a8 = a; b8 = b;
        @(negedge clk);
        s8 = 1'b0; a8 = ~a; b8 = ~b;
        l = 0;
        while (done8 !== 1'b1 && l < 20) begin
            @(negedge clk);
            l++;
        end
        check_eq({tag, " done seen"}, 64'(done8), 64'd1);
        check_eq({tag, " product"}, 64'(p8), 64'(exp));
`ifndef BOOTH_EARLY_TERM_EN
        check_eq({tag, " latency"}, 64'(l), 64'd5);
`endif
        @(negedge clk);
        check_eq({tag, " done/busy after"}, {62'd0, done8, busy8}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        s32 = 1'b0; sg32 = 1'b0; a32 = '0; b32 = '0;
        s8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;
        #12;
        check_eq("reset busy32/done32", {62'd0, busy32, done32}, 64'd0);
        check_eq("reset product32", p32, 64'd0);
        check_eq("reset product8", 64'(p8), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        op32("u32 zero",      1'b0, 32'h0000_0000, 32'h0000_1234, 64'h0);
        op32("u32 max*max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        op32("s32 -7*6",      1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6);
        op32("u32 fff9*6",    1'b0, 32'hFFFF_FFF9, 32'h0000_0006, 64'h0000_0005_FFFF_FFD6);
        op32("s32 min*min",   1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        op32("s32 max*min",   1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

        op8("s8 80*80", 1'b1, 8'h80, 8'h80, 16'h4000);
        op8("s8 7f*80", 1'b1, 8'h7F, 8'h80, 16'hC080);
        op8("u8 ff*ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);

        // Reset in the middle of a calculation
        @(negedge clk);
        s32 = 1'b1; sg32 = 1'b0; a32 = 32'd3; b32 = 32'd5;
        @(negedge clk);
        s32 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("rst mid busy/done", {62'd0, busy32, done32}, 64'd0);
        check_eq("rst mid product", p32, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done32 === 1'b1) pulses++;
        end
        check_eq("rst no done pulse", 64'(pulses), 64'd0);
        op32("rst retry 3*5", 1'b0, 32'd3, 32'd5, 64'd15);

        // Start held high throughout busy, including DONE; back-to-back accept in IDLE
        @(negedge clk);
        s8 = 1'b1; sg8 = 1'b1; a8 = 8'hFD; b8 = 8'h07;
        @(negedge clk);
        sg8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            a8 = a8 + 8'd1;
        end
        check_eq("b2b first done", 64'(done8), 64'd1);
        check_eq("b2b first product", 64'(p8), 64'hFFEB);
`ifndef BOOTH_EARLY_TERM_EN
        check_eq("b2b first latency", 64'(lat), 64'd5);
`endif
        @(negedge clk);
        check_eq("b2b idle done/busy", {62'd0, done8, busy8}, 64'd0);
        sg8 = 1'b0; a8 = 8'hC8; b8 = 8'h0A;
        @(negedge clk);
        s8 = 1'b0;
        check_eq("b2b second busy", 64'(busy8), 64'd1);
        check_eq("b2b product held", 64'(p8), 64'hFFEB);
        lat = 0;
        while (done8 !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("b2b second done", 64'(done8), 64'd1);
        check_eq("b2b second product", 64'(p8), 64'h07D0);
`ifndef BOOTH_EARLY_TERM_EN
        check_eq("b2b second latency", 64'(lat), 64'd5);
`endif
        @(negedge clk);
        check_eq("b2b second after", {62'd0, done8, busy8}, 64'd0);

`ifdef BOOTH_EARLY_TERM_EN
        op32("et 1234*1", 1'b1, 32'd1234, 32'd1, 64'd1234);
        check_eq("et 1234*1 cycles", 64'(last_cu32), 64'd1);
        op32("et 1234*-1", 1'b1, 32'd1234, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FB2E);
        check_eq("et 1234*-1 cycles", 64'(last_cu32), 64'd1);
        op32("et 1234*2^30", 1'b1, 32'd1234, 32'h4000_0000, 64'h0000_0134_8000_0000);
        check_eq("et 1234*2^30 cycles", 64'(last_cu32), 64'd16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
